// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared states, pair table constants and saturation helpers for motion_controller
package motion_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CNV_R,
        ST_WAIT_R,
        ST_CNV_L,
        ST_WAIT_L,
        ST_NEXT,
        ST_CALC
    } state_e;

    typedef enum logic [1:0] {
        PAIR_IN,
        PAIR_MID,
        PAIR_OUT
    } pair_e;

    localparam logic [2:0] CH_IN_R  = 3'd1;
    localparam logic [2:0] CH_IN_L  = 3'd0;
    localparam logic [2:0] CH_MID_R = 3'd4;
    localparam logic [2:0] CH_MID_L = 3'd2;
    localparam logic [2:0] CH_OUT_R = 3'd3;
    localparam logic [2:0] CH_OUT_L = 3'd7;

    localparam logic [1:0] WSH_IN  = 2'd0;
    localparam logic [1:0] WSH_MID = 2'd1;
    localparam logic [1:0] WSH_OUT = 2'd2;

    function automatic logic signed [11:0] sat12(input logic signed [23:0] x);
        if (x > 24'sd2047) begin
            return 12'sh7ff;
        end else if (x < -24'sd2048) begin
            return 12'sh800;
        end else begin
            return x[11:0];
        end
    endfunction

    function automatic logic signed [10:0] sat11(input logic signed [23:0] x);
        if (x > 24'sd1023) begin
            return 11'sh3ff;
        end else if (x < -24'sd1024) begin
            return 11'sh400;
        end else begin
            return x[10:0];
        end
    endfunction

endpackage

// File: rtl/motion_pi_calc.sv
// rtl/motion_pi_calc.sv - registered PI step: error, saturating integrator, correction and lft/rht duty
module motion_pi_calc
    import motion_pkg::*;
#(
    parameter int KP        = 16,
    parameter int KI        = 4,
    parameter int FWD_SPEED = 480
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               calc_en_i,
    input  logic signed [15:0] accum_i,
    output logic signed [10:0] lft_o,
    output logic signed [10:0] rht_o
);

    localparam logic signed [23:0] KP_S  = 24'(KP);
    localparam logic signed [23:0] KI_S  = 24'(KI);
    localparam logic signed [23:0] FWD_S = 24'(FWD_SPEED);

    logic signed [11:0] intgrl_q, intgrl_d;
    logic signed [10:0] lft_q, lft_d;
    logic signed [10:0] rht_q, rht_d;
    logic signed [11:0] error;
    logic signed [23:0] accum_w, error_w, intgrl_w, intgrl_new_w;
    logic signed [23:0] prod_p, prod_i, corr;

    always_comb begin
        accum_w      = {{8{accum_i[15]}}, accum_i};
        error        = sat12(accum_w);
        error_w      = {{12{error[11]}}, error};
        intgrl_w     = {{12{intgrl_q[11]}}, intgrl_q};
        intgrl_d     = sat12(intgrl_w + (error_w >>> 4));
        intgrl_new_w = {{12{intgrl_d[11]}}, intgrl_d};
        prod_p       = error_w * KP_S;
        prod_i       = intgrl_new_w * KI_S;
        // Arithmetic shift floors toward minus infinity, so small negative sums round down.
        corr         = (prod_p + prod_i) >>> 8;
        lft_d        = sat11(FWD_S + corr);
        rht_d        = sat11(FWD_S - corr);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            intgrl_q <= '0;
            lft_q    <= '0;
            rht_q    <= '0;
        end else if (calc_en_i) begin
            intgrl_q <= intgrl_d;
            lft_q    <= lft_d;
            rht_q    <= rht_d;
        end
    end

    assign lft_o = lft_q;
    assign rht_o = rht_q;

endmodule

// File: rtl/motion_controller.sv
// rtl/motion_controller.sv - scans three IR pairs through the A2D and drives PI-corrected motor duty
module motion_controller
    import motion_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4096,
    parameter int KP            = 16,
    parameter int KI            = 4,
    parameter int FWD_SPEED     = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               cnv_cmplt,
    input  logic [11:0]        res,
    output logic               strt_cnv,
    output logic [2:0]         chnnl,
    output logic               IR_in_en,
    output logic               IR_mid_en,
    output logic               IR_out_en,
    output logic signed [10:0] lft,
    output logic signed [10:0] rht
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_e             state_q, state_d;
    pair_e              pair_q, pair_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [15:0] accum_q, accum_d;
    logic signed [15:0] sample_w;
    logic [2:0]         ch_r, ch_l;
    logic [1:0]         wsh;
    logic               calc_en;
    logic               pi_clr;
    logic               pair_active;

    always_comb begin
        ch_r = CH_IN_R;
        ch_l = CH_IN_L;
        wsh  = WSH_IN;
        case (pair_q)
            PAIR_MID: begin
                ch_r = CH_MID_R;
                ch_l = CH_MID_L;
                wsh  = WSH_MID;
            end
            PAIR_OUT: begin
                ch_r = CH_OUT_R;
                ch_l = CH_OUT_L;
                wsh  = WSH_OUT;
            end
            default: ;
        endcase
        sample_w = $signed({4'b0000, res} << wsh);
    end

    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        cnt_d   = '0;
        accum_d = accum_q;
        calc_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accum_d = '0;
                pair_d  = PAIR_IN;
                if (go) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CNV_R;
                end
            end
            ST_CNV_R: state_d = ST_WAIT_R;
            ST_WAIT_R: begin
                if (cnv_cmplt) begin
                    accum_d = accum_q + sample_w;
                    state_d = ST_CNV_L;
                end
            end
            ST_CNV_L: state_d = ST_WAIT_L;
            ST_WAIT_L: begin
                if (cnv_cmplt) begin
                    accum_d = accum_q - sample_w;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                case (pair_q)
                    PAIR_IN: begin
                        pair_d  = PAIR_MID;
                        state_d = ST_SETTLE;
                    end
                    PAIR_MID: begin
                        pair_d  = PAIR_OUT;
                        state_d = ST_SETTLE;
                    end
                    default: state_d = ST_CALC;
                endcase
            end
            ST_CALC: begin
                calc_en = 1'b1;
                accum_d = '0;
                pair_d  = PAIR_IN;
                state_d = ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Dropping go abandons the pass from any state, including a conversion in flight.
        if (!go) begin
            state_d = ST_IDLE;
            pair_d  = PAIR_IN;
            cnt_d   = '0;
            accum_d = '0;
            calc_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pair_q  <= PAIR_IN;
            cnt_q   <= '0;
            accum_q <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            cnt_q   <= cnt_d;
            accum_q <= accum_d;
        end
    end

    always_comb begin
        pair_active = (state_q == ST_SETTLE) || (state_q == ST_CNV_R) || (state_q == ST_WAIT_R)
                   || (state_q == ST_CNV_L) || (state_q == ST_WAIT_L);
        strt_cnv    = (state_q == ST_CNV_R) || (state_q == ST_CNV_L);
        chnnl       = 3'd0;
        if ((state_q == ST_CNV_R) || (state_q == ST_WAIT_R)) begin
            chnnl = ch_r;
        end else if ((state_q == ST_CNV_L) || (state_q == ST_WAIT_L)) begin
            chnnl = ch_l;
        end
        IR_in_en  = pair_active && (pair_q == PAIR_IN);
        IR_mid_en = pair_active && (pair_q == PAIR_MID);
        IR_out_en = pair_active && (pair_q == PAIR_OUT);
    end

    assign pi_clr = !go || (state_q == ST_IDLE);

    motion_pi_calc #(
        .KP        (KP),
        .KI        (KI),
        .FWD_SPEED (FWD_SPEED)
    ) u_pi_calc (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (pi_clr),
        .calc_en_i (calc_en),
        .accum_i   (accum_q),
        .lft_o     (lft),
        .rht_o     (rht)
    );

endmodule

// File: tb/tb_motion_controller.sv
// tb/tb_motion_controller.sv - self-checking bench for motion_controller with an A2D responder and PI reference model
module tb_motion_controller;

    localparam int S   = 16;
    localparam int KP  = 16;
    localparam int KI  = 4;
    localparam int FWD = 480;

    logic               clk = 1'b0;
    logic               rst, go, cnv_cmplt;
    logic [11:0]        res;
    logic               strt_cnv;
    logic [2:0]         chnnl;
    logic               IR_in_en, IR_mid_en, IR_out_en;
    logic signed [10:0] lft, rht;

    always #5 clk = ~clk;

    motion_controller #(
        .SETTLE_CYCLES (S),
        .KP            (KP),
        .KI            (KI),
        .FWD_SPEED     (FWD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .IR_in_en  (IR_in_en),
        .IR_mid_en (IR_mid_en),
        .IR_out_en (IR_out_en),
        .lft       (lft),
        .rht       (rht)
    );

    typedef struct {
        logic [7:0][11:0] v;
        int               passes;
        int               exp_l;
        int               exp_r;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0][11:0] ch_val;
    int  lat;
    bit  a2d_on;
    int  passes_done = 0, en_err = 0, strt_err = 0, chnnl_err = 0, n_strt = 0;
    int  cnv_log[$];
    int  settle_log[$];
    int  pend, pend_ch, en_run;
    bit  prev_strt;

    // A2D responder plus protocol monitor, sampling 1 time unit after each rising edge.
    initial begin
        cnv_cmplt = 1'b0;
        res       = '0;
        pend      = 0;
        pend_ch   = 0;
        en_run    = 0;
        prev_strt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnv_cmplt = 1'b0;
            if ($countones({IR_in_en, IR_mid_en, IR_out_en}) > 1) en_err++;
            if (strt_cnv && prev_strt) strt_err++;
            if (strt_cnv) n_strt++;
            prev_strt = strt_cnv;
            if (strt_cnv && (chnnl == 3'd1 || chnnl == 3'd4 || chnnl == 3'd3)) settle_log.push_back(en_run);
            en_run = (IR_in_en || IR_mid_en || IR_out_en) ? en_run + 1 : 0;
            if (!a2d_on) begin
                pend = 0;
            end else if (pend > 0) begin
                if (int'(chnnl) != pend_ch) chnnl_err++;
                pend--;
                if (pend == 0) begin
                    cnv_cmplt = 1'b1;
                    res       = ch_val[pend_ch];
                    if (pend_ch == 7) passes_done++;
                end
            end else if (strt_cnv) begin
                pend_ch = int'(chnnl);
                pend    = lat;
                cnv_log.push_back(int'(chnnl));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int outs();
        return int'({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, lft, rht});
    endfunction

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    task automatic model_pass(input logic [7:0][11:0] v, inout int integ, output int l, output int r);
        int acc, err, corr;
        acc   = (int'(v[1]) - int'(v[0])) + 2 * (int'(v[4]) - int'(v[2])) + 4 * (int'(v[3]) - int'(v[7]));
        err   = clampi(acc, -2048, 2047);
        integ = clampi(integ + fdiv(err, 16), -2048, 2047);
        corr  = fdiv(err * KP + integ * KI, 256);
        l     = clampi(FWD + corr, -1024, 1023);
        r     = clampi(FWD - corr, -1024, 1023);
    endtask

    task automatic restart(input logic [7:0][11:0] v, input int l);
        go     = 1'b0;
        a2d_on = 1'b0;
        tick(2);
        ch_val = v;
        lat    = l;
        a2d_on = 1'b1;
        go     = 1'b1;
    endtask

    task automatic wait_passes(input int n);
        int base, t;
        base = passes_done;
        t    = 0;
        while (passes_done < base + n && t < 3000) begin
            tick(1);
            t++;
        end
        if (passes_done < base + n) check("pass_timeout", passes_done, base + n);
        else tick(3);
    endtask

    initial begin
        vec_t             tbl[$];
        logic [7:0][11:0] v;
        int               k, cidx, sidx, integ, el, er;
        int               exp_seq[6] = '{1, 0, 4, 2, 3, 7};

        rst    = 1'b1;
        go     = 1'b1;
        a2d_on = 1'b0;
        lat    = 1;
        ch_val = '0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("reset_outs%0d", i), outs(), 0);
        end
        rst = 1'b0;
        go  = 1'b0;
        tick(10);
        check("idle_outs", outs(), 0);
        check("idle_no_strt", n_strt, 0);

        v    = {8{12'h400}};
        cidx = cnv_log.size();
        sidx = settle_log.size();
        restart(v, 1);
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!strt_cnv && k < 100);
        check("first_strt_latency", k, S + 1);
        wait_passes(1);
        for (int i = 0; i < 6; i++) check($sformatf("chnnl_seq%0d", i), cnv_log[cidx + i], exp_seq[i]);
        for (int i = 0; i < 3; i++) check($sformatf("settle_len%0d", i), settle_log[sidx + i], S);
        check("balanced_lft", int'(lft), 480);
        check("balanced_rht", int'(rht), 480);

        v = {8{12'h400}};                         tbl.push_back('{v, 1, 480, 480});
        v = '0; v[1] = 12'd100;                   tbl.push_back('{v, 1, 486, 474});
        v = '0; v[1] = 12'd100;                   tbl.push_back('{v, 2, 486, 474});
        v = '0; v[7] = 12'd4095;                  tbl.push_back('{v, 1, 350, 610});
        v = '0; v[1] = 12'd4095; v[4] = 12'd4095; v[3] = 12'd4095;
                                                  tbl.push_back('{v, 1, 609, 351});
        v = '0; v[0] = 12'd4095; v[2] = 12'd4095; v[7] = 12'd4095;
                                                  tbl.push_back('{v, 1, 350, 610});
        v = '0; v[2] = 12'd512;                   tbl.push_back('{v, 1, 415, 545});
        foreach (tbl[i]) begin
            restart(tbl[i].v, 1 + (i % 3));
            wait_passes(tbl[i].passes);
            check($sformatf("vec%0d_lft", i), int'(lft), tbl[i].exp_l);
            check($sformatf("vec%0d_rht", i), int'(rht), tbl[i].exp_r);
        end

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) v[c] = ($urandom_range(0, 3) == 0) ? 12'd4095 : 12'($urandom_range(0, 4095));
            restart(v, int'($urandom_range(1, 4)));
            integ = 0;
            for (int p = 0; p < 3; p++) begin
                wait_passes(1);
                model_pass(v, integ, el, er);
                check($sformatf("rand%0d_p%0d_lft", r, p), int'(lft), el);
                check($sformatf("rand%0d_p%0d_rht", r, p), int'(rht), er);
            end
        end

        v = '0;
        v[7] = 12'd4095;
        restart(v, 2);
        wait_passes(1);
        check("abort_pre1_lft", int'(lft), 350);
        check("abort_pre1_rht", int'(rht), 610);
        wait_passes(1);
        check("abort_pre2_lft", int'(lft), 348);
        check("abort_pre2_rht", int'(rht), 612);
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!(strt_cnv && chnnl == 3'd0) && k < 200);
        check("abort_find_cnv_l", int'(strt_cnv && chnnl == 3'd0), 1);
        tick(2);
        go = 1'b0;
        tick(1);
        check("abort_idle_outs", outs(), 0);
        v    = '0;
        cidx = cnv_log.size();
        restart(v, 1);
        wait_passes(1);
        check("restart_first_ch", cnv_log[cidx], 1);
        check("restart_lft", int'(lft), 480);
        check("restart_rht", int'(rht), 480);

        check("enable_onehot", en_err, 0);
        check("strt_one_cycle", strt_err, 0);
        check("chnnl_stable", chnnl_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/motion_controller.md
# motion_controller

Line-following motion controller for the robot's digital core. While `go` is high it scans three pairs of IR sensors through the shared A2D interface. It forms a weighted left/right error, runs a saturating PI loop, and drives signed 11-bit duty commands `lft`/`rht` to the motor controller. It sits between the A2D interface (`strt_cnv`/`chnnl`/`cnv_cmplt`/`res` handshake) and the motor PWM block.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4096: clocks an IR pair is enabled before its first conversion starts.
- `KP`, default 16: proportional gain, unsigned.
- `KI`, default 4: integral gain, unsigned.
- `FWD_SPEED`, default 480: base duty, signed 11-bit.

Ports:
- `clk` input 1: the single clock; everything is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `go` input 1: run enable, level-sensitive.
- `cnv_cmplt` input 1: one-cycle pulse from the A2D when a conversion is done.
- `res` input 12: A2D result, unsigned, valid while `cnv_cmplt` is high.
- `strt_cnv` output 1: one-cycle conversion request.
- `chnnl` output 3: A2D channel, held stable from `strt_cnv` until `cnv_cmplt`.
- `IR_in_en`, `IR_mid_en`, `IR_out_en` output 1 each: IR emitter enables for the inner, middle and outer pairs.
- `lft`, `rht` output 11: signed duty commands.

## Operation
- Pair table, applied in this order:
  - inner: right ch1, left ch0, weight 1.
  - middle: right ch4, left ch2, weight 2.
  - outer: right ch3, left ch7, weight 4.
- States: IDLE, SETTLE, CNV_R, WAIT_R, CNV_L, WAIT_L, NEXT, CALC.
- IDLE:
  - `lft`, `rht`, `strt_cnv` and all enables are 0; the accumulator and integrator are cleared.
  - Moves to SETTLE with pair = inner when `go`=1.
- SETTLE: only the current pair's enable is high. After `SETTLE_CYCLES` clocks, go to CNV_R.
- CNV_R: `strt_cnv`=1 for one cycle with the right channel, then go to WAIT_R.
- WAIT_R: on `cnv_cmplt`, accum += res·weight, then go to CNV_L.
- CNV_L / WAIT_L: same as the right side with the left channel; on `cnv_cmplt`, accum −= res·weight.
- NEXT: drop the enable. Advance to the next pair (go to SETTLE), or after the outer pair go to CALC.
- CALC (one cycle):
  - error = sat12(accum), range −2048..2047.
  - intgrl = sat12(intgrl + (error>>>4)).
  - corr = (error·KP + intgrl_new·KI)>>>8.
  - lft = sat11(FWD_SPEED + corr); rht = sat11(FWD_SPEED − corr).
  - Clear accum and go to SETTLE with pair = inner.
- Widths and clamping:
  - accum is 16-bit signed; the extremes are ±28665, so it cannot overflow.
  - Products are 24-bit signed.
  - sat11 clamps to −1024..1023.
- `lft`/`rht` hold their last values between CALC cycles.
- `go` falling in any state: the next state is IDLE with everything cleared. A pending `cnv_cmplt` is ignored.
- `cnv_cmplt` outside WAIT_R/WAIT_L is ignored, including in the same cycle as `strt_cnv`.
- `rst` mid-operation behaves exactly like `go` falling, and takes priority over `go`.

## Timing
- Reset values: all outputs 0, `chnnl`=0, state IDLE.
- The first `strt_cnv` occurs `SETTLE_CYCLES`+1 clocks after `go` is sampled high.
- Per pair: SETTLE_CYCLES + 2 + 2·(A2D latency) + 1 clocks.
- `lft`/`rht` update on the clock edge after CALC, which is 2 clocks after the last `cnv_cmplt` of a pass.
- Exactly one enable is high at a time; none is high in NEXT, CALC or IDLE.

## Structure
- Shared package `motion_pkg` holds:
  - the state enum;
  - channel constants CH_IN_R=1, CH_IN_L=0, CH_MID_R=4, CH_MID_L=2, CH_OUT_R=3, CH_OUT_L=7;
  - weight shifts 0/1/2;
  - `sat12` and `sat11` functions.
- One sub-module, `motion_pi_calc`: the registered CALC arithmetic (error, integrator, corr, saturated lft/rht). The sequencing FSM stays in the top level.

## Test plan
1. Reset: hold `rst`=1 with `go`=1 → all outputs stay 0. Release `rst` with `go`=0 → the block stays in IDLE.
2. Sequence (`SETTLE_CYCLES`=16): `go`=1 → `strt_cnv` pulses occur with `chnnl` 1,0,4,2,3,7. Each pulse is one cycle long. The matching enable has been high for exactly 16 clocks before the first conversion of its pair.
3. Balanced inputs: every `res`=0x400 → after the first pass `lft`=`rht`=480.
4. Inner-right `res`=100, all others 0 → first pass gives error=100, intgrl=6, corr=6, so `lft`=486 and `rht`=474. The second pass gives intgrl=12, corr=6, so the outputs are unchanged.
5. Outer-left `res`=4095, all others 0 → error=−2048, intgrl=−128, corr=−130, so `lft`=350 and `rht`=610.
6. Drop `go` while in WAIT_L, then send `cnv_cmplt` → the next cycle is IDLE with outputs 0. Raising `go` again restarts from the inner pair with the integrator at 0.
